// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset fetch address and instruction-queue payload for the fetch front end.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_START_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = ~64'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_inst_queue.sv
// Circular FIFO of {pc, inst} entries between the fetch response path and decode.
module if_inst_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so an empty queue presents zero head data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, response queue, redirect flush.
// Optional IF_PERF_CNT_EN adds fetch/drop/stall performance counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_START    = PC_START_DEFAULT,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_drop_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  redirect_target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] q_count;
  logic [SUM_W-1:0] credit_used;
  logic             fetch_en;
  logic             req_fire;
  logic             resp_drop;
  logic             push;
  logic             pop;
  logic             q_empty;
  logic             q_full;
  fetch_entry_t     q_wr;
  fetch_entry_t     q_head;

  assign redirect_target = redirect_pc & PC_ALIGN_MASK;
  assign credit_used     = SUM_W'(q_count) + SUM_W'(outstanding);

  // Queue slots are reserved at request time, so a response always has room.
  assign imem_req_valid = fetch_en && !redirect_valid
                       && (credit_used < SUM_W'(QUEUE_DEPTH))
                       && ((drop_cnt == '0) || (outstanding < CNT_W'(QUEUE_DEPTH)));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop  = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
  assign push       = imem_resp_valid && !resp_drop;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign q_wr       = {resp_pc, imem_resp_data};
  assign inst_valid = !q_empty;
  assign inst_pc    = q_head.pc;
  assign inst       = q_head.inst;

  always_comb begin
    outstanding_next = outstanding;
    unique case ({req_fire, imem_resp_valid})
      2'b10:   outstanding_next = outstanding + CNT_W'(1);
      2'b01:   outstanding_next = outstanding - CNT_W'(1);
      default: ;
    endcase
  end

  // Redirect wins: restart both PCs and drop whatever is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_en    <= 1'b0;
      fetch_pc    <= PC_START;
      resp_pc     <= PC_START;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_en    <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (push)     resp_pc  <= resp_pc + PC_STEP;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  if_inst_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (q_wr),
    .head    (q_head),
    .count   (q_count),
    .empty   (q_empty),
    .full    (q_full)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && q_full));

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)                    perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      if (resp_drop)               perf_drop_cnt  <= perf_drop_cnt + XLEN'(1);
      if (inst_valid && !inst_ready) perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order, 1-cycle-latency imem responder.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst;
`ifdef IF_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_drop_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [63:0] pend[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic        hold;
  logic [63:0] exp_next;
  int          acc_cnt = 0;
  int          resp_cnt = 0;
  int          max_out = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst            (inst)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_drop_cnt   (perf_drop_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample handshakes mid-cycle, then drive the next response after the edge.
  task automatic tick();
    logic [63:0] a;
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin pend.push_back(imem_req_addr); acc_cnt++; end
    if (imem_resp_valid) resp_cnt++;
    if (inst_valid && inst_ready) begin got_pc.push_back(inst_pc); got_inst.push_back(inst); end
    if (acc_cnt - resp_cnt > max_out) max_out = acc_cnt - resp_cnt;
    @(posedge clk);
    #1;
    if (!hold && pend.size() > 0) begin
      a = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = a[31:0] + 32'd3;
    end else begin
      imem_resp_valid = 1'b0;
    end
  endtask

  task automatic wait_got(input int need, input int budget);
    for (int n = 0; n < budget && got_pc.size() < need; n++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1; hold = 1'b0;
    repeat (3) tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
    checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL reset_req_addr: got %h want 80000000", imem_req_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [63:0] p; logic [31:0] w;
    exp_next = 64'h8000_0000; max_out = 0;
    wait_got(6, 40);
    checks++; if (got_pc.size() < 6) begin errors++; $display("FAIL stream_count: got %0d want 6", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL stream_order: pc=%h inst=%h want pc=%h inst=%h", p, w, exp_next, exp_next[31:0] + 32'd3); end
      exp_next += 64'd4;
    end
    checks++; if (max_out > 2) begin errors++; $display("FAIL stream_outstanding: got %0d want <=2", max_out); end
  endtask

  task automatic test_backpressure();
    logic [63:0] p; logic [31:0] w;
    inst_ready = 1'b0;
    repeat (10) tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %0b want 1", inst_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %0b want 0", imem_req_valid); end
    checks++; if (inst_pc !== exp_next) begin errors++; $display("FAIL bp_head_pc: got %h want %h", inst_pc, exp_next); end
    inst_ready = 1'b1;
    repeat (12) tick();
    checks++; if (got_pc.size() < 4) begin errors++; $display("FAIL bp_drain_count: got %0d want >=4", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL bp_order: pc=%h inst=%h want pc=%h inst=%h", p, w, exp_next, exp_next[31:0] + 32'd3); end
      exp_next += 64'd4;
    end
  endtask

  task automatic test_redirect_outstanding();
    logic [63:0] p; logic [31:0] w;
    hold = 1'b1;
    repeat (8) tick();
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL redir_pre_order: pc=%h want %h", p, exp_next); end
      exp_next += 64'd4;
    end
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL redir_outstanding: got %0d want 2", pend.size()); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1002; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle_req: got %0b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0; hold = 1'b0; #1;
    checks++; if (imem_req_addr !== 64'h8000_1000) begin errors++; $display("FAIL redir_addr: got %h want 80001000", imem_req_addr); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %0b want 0", imem_req_valid); end
    exp_next = 64'h8000_1000;
    wait_got(2, 30);
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL redir_count: got %0d want 2", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL redir_order: pc=%h inst=%h want pc=%h inst=%h", p, w, exp_next, exp_next[31:0] + 32'd3); end
      exp_next += 64'd4;
    end
`ifdef IF_PERF_CNT_EN
    checks++; if (perf_drop_cnt !== 64'd2) begin errors++; $display("FAIL perf_drop_2: got %0d want 2", perf_drop_cnt); end
`endif
  endtask

  task automatic test_redirect_collision();
    logic [63:0] p; logic [31:0] w; logic [63:0] a;
    inst_ready = 1'b0; hold = 1'b0;
    repeat (8) tick();
    hold = 1'b1; inst_ready = 1'b1; tick();
    inst_ready = 1'b0; tick();
    checks++; if (pend.size() != 1 || inst_valid !== 1'b1) begin errors++; $display("FAIL coll_setup: pend=%0d inst_valid=%0b want 1/1", pend.size(), inst_valid); end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1237;
    a = pend.pop_front(); imem_resp_valid = 1'b1; imem_resp_data = a[31:0] + 32'd3;
    tick();
    redirect_valid = 1'b0; hold = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coll_flush: inst_valid=%0b want 0", inst_valid); end
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL coll_drop_zero: req_valid=%0b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h1234) begin errors++; $display("FAIL coll_addr: got %h want 1234", imem_req_addr); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL coll_pre_order: pc=%h want %h", p, exp_next); end
      exp_next += 64'd4;
    end
    exp_next = 64'h1234;
    wait_got(1, 20);
    checks++; if (got_pc.size() < 1) begin errors++; $display("FAIL coll_timeout: no delivery"); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL coll_order: pc=%h inst=%h want pc=%h", p, w, exp_next); end
      exp_next += 64'd4;
    end
`ifdef IF_PERF_CNT_EN
    checks++; if (perf_drop_cnt !== 64'd3) begin errors++; $display("FAIL perf_drop_3: got %0d want 3", perf_drop_cnt); end
`endif
  endtask

  task automatic test_req_stall();
    logic [63:0] p; logic [31:0] w;
    imem_req_ready = 1'b0;
    repeat (6) tick();
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL stall_pre_order: pc=%h want %h", p, exp_next); end
      exp_next += 64'd4;
    end
    for (int i = 0; i < 5; i++) begin
      tick(); checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_next) begin errors++; $display("FAIL stall_hold: valid=%0b addr=%h want 1/%h", imem_req_valid, imem_req_addr, exp_next); end
    end
    redirect_valid = 1'b1; redirect_pc = 64'h2000_0000_0000_0041; #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== exp_next) begin errors++; $display("FAIL stall_redir_cycle: valid=%0b addr=%h want 0/%h", imem_req_valid, imem_req_addr, exp_next); end
    tick();
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000_0000_0000_0040) begin errors++; $display("FAIL stall_redir_addr: valid=%0b addr=%h want 1/2000000000000040", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    exp_next = 64'h2000_0000_0000_0040;
    wait_got(2, 20);
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL stall_timeout: got %0d want 2", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL stall_order: pc=%h inst=%h want pc=%h", p, w, exp_next); end
      exp_next += 64'd4;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] p; logic [31:0] w;
    hold = 1'b1; inst_ready = 1'b1;
    repeat (8) tick();
    got_pc.delete(); got_inst.delete();
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL rst_burst_setup: pend=%0d want 2", pend.size()); end
    rst_n = 1'b0; imem_resp_valid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_burst_outputs: inst_valid=%0b req_valid=%0b want 0/0", inst_valid, imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL rst_burst_addr: got %h want 80000000", imem_req_addr); end
    pend.delete(); acc_cnt = 0; resp_cnt = 0; hold = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_next = 64'h8000_0000;
    wait_got(2, 20);
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL rst_burst_timeout: got %0d want 2", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front(); checks++;
      if (p !== exp_next || w !== exp_next[31:0] + 32'd3) begin errors++; $display("FAIL rst_burst_order: pc=%h inst=%h want pc=%h", p, w, exp_next); end
      exp_next += 64'd4;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_collision();
    test_req_stall();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
